// File: rtl/sr_drv_pkg.sv
// Shared types and limits for the SR bank driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned MIN_PULSE_CYC = 1;
  localparam int unsigned MIN_GAP_CYC   = 1;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter; done flags the final cycle of a loaded interval.
module sr_pulse_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/sr_bank_driver.sv
// Writer for a bank of SR flops: computes set/clear masks against a shadow,
// issues disjoint timed s/r pulses, then verifies the bank feedback.
module sr_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [N-1:0] req_data,
  output logic         req_ready,
  input  logic         clear_all,
  output logic [N-1:0] s,
  output logic [N-1:0] r,
  input  logic [N-1:0] fb_q,
  output logic [N-1:0] q_shadow,
  output logic         busy,
  output logic         err
);

  localparam int unsigned MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  if ((N < 1) || (PULSE_CYC < MIN_PULSE_CYC) || (GAP_CYC < MIN_GAP_CYC)) begin : g_param_check
    $error("sr_bank_driver: illegal parameter values");
  end

  state_t         state, nstate;
  logic [N-1:0]   set_m, clr_m, set_c, clr_c, set_nx, clr_nx;
  logic           t_load, t_count, t_done;
  logic [CW-1:0]  t_val;

  assign set_c = req_data & ~q_shadow;
  assign clr_c = ~req_data & q_shadow;

  sr_pulse_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .done     (t_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    set_nx = set_m;
    clr_nx = clr_m;
    case (state)
      IDLE: begin
        if (clear_all) begin
          set_nx = '0;
          clr_nx = '1;
          nstate = PULSE;
        end else if (req_valid && ((set_c | clr_c) != '0)) begin
          set_nx = set_c;
          clr_nx = clr_c;
          nstate = PULSE;
        end
      end
      PULSE:   if (t_done) nstate = GAP;
      GAP:     if (t_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !clear_all;
    busy      = (state != IDLE);
    t_load    = (nstate != state);
    t_count   = busy && !t_load;
    t_val     = (nstate == GAP) ? CW'(GAP_CYC) : CW'(PULSE_CYC);
  end

  // s/r are registered from the next-state view so they line up with PULSE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      set_m    <= '0;
      clr_m    <= '0;
      s        <= '0;
      r        <= '0;
      q_shadow <= '0;
      err      <= 1'b0;
    end else begin
      set_m <= set_nx;
      clr_m <= clr_nx;
      s     <= (nstate == PULSE) ? set_nx : '0;
      r     <= (nstate == PULSE) ? clr_nx : '0;
      if ((state == PULSE) && t_done) q_shadow <= (q_shadow | set_m) & ~clr_m;
      if ((state == GAP) && t_done && (fb_q != q_shadow)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed, table-driven bench for sr_bank_driver against a behavioural SR bank.
module tb_sr_bank_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = '0;
  logic       req_ready;
  logic       clear_all = 1'b0;
  logic [7:0] s, r, fb_q, q_shadow;
  logic       busy, err;
  logic [7:0] bank = '0;
  logic [7:0] stuck0 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_bank_driver #(.N(8), .PULSE_CYC(2), .GAP_CYC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clear_all (clear_all),
    .s         (s),
    .r         (r),
    .fb_q      (fb_q),
    .q_shadow  (q_shadow),
    .busy      (busy),
    .err       (err)
  );

  // Behavioural SR bank; stuck0 forces selected feedback bits low.
  always @(posedge clk) bank <= (bank | s) & ~r;
  assign fb_q = bank & ~stuck0;

  typedef struct {
    logic       rst, ca, rv;
    logic [7:0] rd;
    logic       chk;
    logic [7:0] es, er, esh;
    logic       erdy, ebusy, eerr;
  } vec_t;

  function automatic vec_t row(input logic rst, ca, rv, input logic [7:0] rd,
                               input logic c, input logic [7:0] es, er, esh,
                               input logic erdy, ebusy, eerr);
    vec_t v;
    v.rst = rst; v.ca = ca; v.rv = rv; v.rd = rd; v.chk = c;
    v.es = es; v.er = er; v.esh = esh; v.erdy = erdy; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One row = one clock cycle: drive inputs, then check outputs within that cycle.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; clear_all = v.ca; req_valid = v.rv; req_data = v.rd;
    #1;
    if (v.chk) begin
      chk({tag, " s"},         s,                v.es);
      chk({tag, " r"},         r,                v.er);
      chk({tag, " q_shadow"},  q_shadow,         v.esh);
      chk({tag, " req_ready"}, {7'd0, req_ready}, {7'd0, v.erdy});
      chk({tag, " busy"},      {7'd0, busy},      {7'd0, v.ebusy});
      chk({tag, " err"},       {7'd0, err},       {7'd0, v.eerr});
      chk({tag, " s_and_r"},   s & r,            8'h00);
    end
  endtask

  vec_t vecs[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                rst ca rv rd     chk s      r      sh     rdy busy err
    vecs[0]  = row(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    vecs[1]  = row(1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    vecs[2]  = row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    vecs[3]  = row(0, 0, 1, 8'hA5, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    vecs[4]  = row(0, 0, 0, 8'h00, 1, 8'hA5, 8'h00, 8'h00, 0, 1, 0);
    vecs[5]  = row(0, 0, 0, 8'h00, 1, 8'hA5, 8'h00, 8'h00, 0, 1, 0);
    vecs[6]  = row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'hA5, 0, 1, 0);
    vecs[7]  = row(0, 0, 1, 8'h3C, 1, 8'h00, 8'h00, 8'hA5, 1, 0, 0);
    vecs[8]  = row(0, 0, 0, 8'h00, 1, 8'h18, 8'h81, 8'hA5, 0, 1, 0);
    vecs[9]  = row(0, 0, 0, 8'h00, 1, 8'h18, 8'h81, 8'hA5, 0, 1, 0);
    vecs[10] = row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h3C, 0, 1, 0);
    vecs[11] = row(0, 0, 1, 8'h3C, 1, 8'h00, 8'h00, 8'h3C, 1, 0, 0);
    vecs[12] = row(0, 0, 1, 8'h3C, 1, 8'h00, 8'h00, 8'h3C, 1, 0, 0);
    vecs[13] = row(0, 0, 1, 8'h3C, 1, 8'h00, 8'h00, 8'h3C, 1, 0, 0);
    vecs[14] = row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h3C, 1, 0, 0);

    for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("row%0d", i));
    chk("bank_after_3C", bank, 8'h3C);

    // Stuck-at-0 on bit 0 must raise sticky err, then clear_all beats req_valid.
    stuck0 = 8'h01;
    apply(row(0, 0, 1, 8'h01, 1, 8'h00, 8'h00, 8'h3C, 1, 0, 0), "stk_acc");
    apply(row(0, 0, 0, 8'h00, 1, 8'h01, 8'h3C, 8'h3C, 0, 1, 0), "stk_p1");
    apply(row(0, 0, 0, 8'h00, 1, 8'h01, 8'h3C, 8'h3C, 0, 1, 0), "stk_p2");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h01, 0, 1, 0), "stk_gap");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1, 0, 1), "stk_err");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1, 0, 1), "stk_hold");
    apply(row(0, 1, 1, 8'h55, 1, 8'h00, 8'h00, 8'h01, 0, 0, 1), "clr_req");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'hFF, 8'h01, 0, 1, 1), "clr_p1");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'hFF, 8'h01, 0, 1, 1), "clr_p2");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 1, 1), "clr_gap");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1), "clr_idle");
    chk("bank_after_clear", bank, 8'h00);

    // Reset during the second PULSE cycle abandons the pulse.
    stuck0 = 8'h00;
    apply(row(0, 0, 1, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1), "rst_acc");
    apply(row(0, 0, 0, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0, 1, 1), "rst_p1");
    apply(row(1, 0, 0, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0, 1, 1), "rst_p2");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0), "rst_after");
    apply(row(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0), "rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_bank_driver.md
# sr_bank_driver

Command-side driver for a bank of N SR flip-flops. Accepts a target bank value over a valid/ready handshake and computes per-bit set/clear masks against a shadow copy of the bank. It then issues timed, never-conflicting s/r pulses followed by a quiet gap, and checks the bank's feedback outputs against the shadow. It sits between control logic and the SR storage elements as the writer for those flops.

## Interface
- N, default 8: bank width, at least 1.
- PULSE_CYC, default 2: cycles that s/r are held per command, at least 1.
- GAP_CYC, default 1: cycles with s=r=0 after each pulse, at least 1.

Ports:
- clk, in, 1: sole clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high; sampled on the rising edge of clk.
- req_valid, in, 1: a target value is offered.
- req_data, in, N: target bank value.
- req_ready, out, 1: the driver can accept a request or clear_all.
- clear_all, in, 1: force every bit to 0; has priority over req_valid.
- s, out, N: set pulses to the bank (registered).
- r, out, N: reset pulses to the bank (registered).
- fb_q, in, N: q outputs fed back from the bank.
- q_shadow, out, N: the value the driver believes the bank holds.
- busy, out, 1: FSM is not in IDLE.
- err, out, 1: sticky mismatch flag; cleared only by reset.

## Operation
- Reset values: s=0, r=0, q_shadow=0, err=0, busy=0, state IDLE, req_ready=1.
- req_ready = (state==IDLE) && !clear_all.
- FSM states: IDLE, PULSE, GAP.
- IDLE, clear_all=1:
  - latch set_m=0 and clr_m={N{1}}, regardless of shadow.
  - go to PULSE.
- IDLE, req_valid && req_ready (accept):
  - set_m = req_data & ~q_shadow.
  - clr_m = ~req_data & q_shadow.
  - If both masks are 0: no-op; stay IDLE with no pulse and no compare.
  - Otherwise go to PULSE.
- PULSE:
  - s=set_m, r=clr_m for exactly PULSE_CYC cycles.
  - On the last PULSE cycle edge: q_shadow <= (q_shadow | set_m) & ~clr_m; go to GAP.
- GAP:
  - s=r=0 for GAP_CYC cycles.
  - On the last GAP cycle: if fb_q != q_shadow, set err.
  - Go to IDLE.
- Invariant: (s & r) == 0 in every cycle. set_m and clr_m are disjoint by construction.
- Requests arriving while busy are not accepted (req_ready=0). The requester must hold req_valid and req_data until acceptance.
- reset in any state returns every output to its reset value on the next edge. Any pulse in progress is abandoned immediately.
- Counter width is $clog2(max(PULSE_CYC,GAP_CYC)+1); the counter reloads on each state entry.

## Timing
- Acceptance at edge T, for a non-no-op request:
  - s/r valid in cycles T+1 … T+PULSE_CYC.
  - q_shadow updated and visible from T+PULSE_CYC+1.
  - Gap occupies cycles T+PULSE_CYC+1 … T+PULSE_CYC+GAP_CYC.
  - err (if set) is visible at T+PULSE_CYC+GAP_CYC+1.
  - req_ready returns high in that same cycle.
- Throughput: one changing command per PULSE_CYC+GAP_CYC+1 cycles. A no-op request can be accepted every cycle.
- clear_all and req_valid both high in IDLE: clear_all wins and the request is not accepted in that cycle.
- fb_q is sampled only in the last GAP cycle. The bank must settle within PULSE_CYC+GAP_CYC cycles.

## Structure
- Shared package sr_drv_pkg holds:
  - the state enum (IDLE, PULSE, GAP);
  - MIN_PULSE_CYC=1 and MIN_GAP_CYC=1, used in parameter assertions.
- One sub-module is natural: sr_pulse_timer, a loadable down-counter with load, count and done signals, instantiated once and reused for both PULSE and GAP.

## Test plan
Bench parameters: N=8, PULSE_CYC=2, GAP_CYC=1, fb_q driven from a behavioural SR bank.
1. Reset held for 2 cycles, then released -> s=r=0x00, q_shadow=0x00, err=0, req_ready=1.
2. From shadow 0x00, accept req_data=0xA5 at T -> s=0xA5, r=0x00 at T+1 and T+2; q_shadow=0xA5 and s=r=0 at T+3; req_ready=1 at T+4; err=0.
3. From shadow 0xA5, accept 0x3C -> s=0x18, r=0x81 for 2 cycles; q_shadow=0x3C; (s&r)==0 checked every cycle.
4. Request 0x3C again with shadow 0x3C -> no pulse, busy stays 0, req_ready stays 1; back-to-back no-ops accepted each cycle.
5. Bank bit 0 forced stuck at 0, then request 0x01 -> err=1 one cycle after the gap and stays 1. Then clear_all=1 together with req_valid=1 -> request not accepted; r=0xFF, s=0x00 for 2 cycles; q_shadow=0x00.
6. Assert reset in the second PULSE cycle of a 0xFF request -> next cycle s=r=0, q_shadow=0x00, state IDLE, err=0, req_ready=1.
